rcn_uart: RTL

UART peripheral that sits as a slave on the 67-bit RCN register ring, between any two existing ring stations (e.g. test registers and SRAM), and drives the board `uart_tx`/`uart_rx` pins. It decodes ring requests to a 4-word register window. It forwards every other packet unchanged after one register stage. Serial format is fixed 8N1 with a programmable divisor, and both directions are buffered by FIFOs.

---
 rtl/rcn_uart.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/rcn_uart.sv
// rcn_uart: RCN ring slave with a 4-word register window and an 8N1 UART.
// Both directions are FIFO-buffered; the bit period is DIV+1 clocks.
module rcn_uart #(
    parameter logic [31:0] ADDR_BASE   = 32'h00FFFFE0,
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [66:0] rcn_in,
    output logic [66:0] rcn_out,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   ONE_C    = 1;
    localparam logic [FIFO_AW-1:0] ONE_P    = 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic        hit, req_wr;
    logic [3:0]  req_mask;
    logic [1:0]  req_reg;
    logic [31:0] wdata, rdata;

    assign req_wr   = rcn_in[64];
    assign req_mask = rcn_in[57:54];
    assign req_reg  = rcn_in[33:32];
    assign wdata    = rcn_in[31:0];
    assign hit      = rcn_in[66] & rcn_in[65] & (rcn_in[53:34] == ADDR_BASE[23:4]);

    logic [15:0] div, div_eff;
    logic        rx_ovr, ferr, tx_ovf;
    assign div_eff = (div < 16'd3) ? 16'd3 : div;

    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wp, tx_rp;
    logic [FIFO_AW:0]   tx_cnt;
    logic               tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;
    state_t             tx_state;
    logic [15:0]        tx_tmr;
    logic [2:0]         tx_bit;
    logic [7:0]         tx_sh;

    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] rx_wp, rx_rp;
    logic [FIFO_AW:0]   rx_cnt;
    logic               rx_full, rx_empty, rx_wr, rx_pop, rx_ovr_set;
    logic               rx_s1, rx_s2, rx_s3, rx_push, rx_ferr_set;
    state_t             rx_state;
    logic [15:0]        rx_tmr;
    logic [2:0]         rx_bit;
    logic [7:0]         rx_sh;

    logic data_wr, stat_clr;
    assign data_wr  = hit & req_wr & (req_reg == 2'd0) & req_mask[0];
    assign stat_clr = hit & req_wr & (req_reg == 2'd1) & req_mask[0];

    assign tx_full    = (tx_cnt == FULL_CNT);
    assign tx_empty   = (tx_cnt == '0);
    assign tx_push    = data_wr & ~tx_full;
    assign tx_ovf_set = data_wr & tx_full;
    assign tx_pop     = ~tx_empty &
                        ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_tmr == '0)));

    assign rx_full    = (rx_cnt == FULL_CNT);
    assign rx_empty   = (rx_cnt == '0);
    assign rx_pop     = hit & ~req_wr & (req_reg == 2'd0) & ~rx_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign rx_wr      = rx_push & (~rx_full | rx_pop);
    assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

    assign irq = ~rx_empty | rx_ovr | ferr | tx_ovf;

    always_comb begin
        rdata = '0;
        if (!req_wr) begin
            unique case (req_reg)
                2'd0:    rdata = {23'b0, ~rx_empty, rx_empty ? 8'h00 : rx_mem[rx_rp]};
                2'd1:    rdata = {25'b0, tx_ovf, ferr, rx_ovr, rx_full, rx_empty,
                                  tx_empty & (tx_state == S_IDLE), tx_full};
                2'd2:    rdata = {16'b0, div};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcn_out <= '0;
        end else if (hit) begin
            rcn_out <= {2'b10, rcn_in[64:32], rdata};
        end else begin
            rcn_out <= rcn_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= DEFAULT_DIV;
            rx_ovr <= 1'b0;
            ferr   <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            if (hit & req_wr & (req_reg == 2'd2)) begin
                if (req_mask[0]) div[7:0]  <= wdata[7:0];
                if (req_mask[1]) div[15:8] <= wdata[15:8];
            end
            rx_ovr <= rx_ovr_set  | (rx_ovr & ~(stat_clr & wdata[4]));
            ferr   <= rx_ferr_set | (ferr   & ~(stat_clr & wdata[5]));
            tx_ovf <= tx_ovf_set  | (tx_ovf & ~(stat_clr & wdata[6]));
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
        if (rx_wr)   rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + ONE_P;
            if (tx_pop)  tx_rp <= tx_rp + ONE_P;
            if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + ONE_C;
            else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - ONE_C;
            if (rx_wr)  rx_wp <= rx_wp + ONE_P;
            if (rx_pop) rx_rp <= rx_rp + ONE_P;
            if (rx_wr & ~rx_pop)      rx_cnt <= rx_cnt + ONE_C;
            else if (~rx_wr & rx_pop) rx_cnt <= rx_cnt - ONE_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_tmr   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_tx  <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= S_START;
            tx_sh    <= tx_mem[tx_rp];
            tx_tmr   <= div_eff;
            uart_tx  <= 1'b0;
        end else if (tx_state != S_IDLE) begin
            if (tx_tmr != '0) begin
                tx_tmr <= tx_tmr - 16'd1;
            end else begin
                tx_tmr <= div_eff;
                unique case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx_bit   <= '0;
                        uart_tx  <= tx_sh[0];
                    end
                    S_DATA: begin
                        tx_sh <= {1'b0, tx_sh[7:1]};
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            uart_tx <= tx_sh[1];
                        end
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_s3       <= 1'b1;
            rx_state    <= S_IDLE;
            rx_tmr      <= '0;
            rx_bit      <= '0;
            rx_sh       <= '0;
            rx_push     <= 1'b0;
            rx_ferr_set <= 1'b0;
        end else begin
            rx_s1       <= uart_rx;
            rx_s2       <= rx_s1;
            rx_s3       <= rx_s2;
            rx_push     <= 1'b0;
            rx_ferr_set <= 1'b0;
            if (rx_state == S_IDLE) begin
                if (rx_s3 & ~rx_s2) begin
                    rx_state <= S_START;
                    rx_tmr   <= {1'b0, div_eff[15:1]};
                end
            end else if (rx_tmr != '0) begin
                rx_tmr <= rx_tmr - 16'd1;
            end else begin
                rx_tmr <= div_eff;
                unique case (rx_state)
                    S_START: begin
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                        rx_bit   <= '0;
                    end
                    S_DATA: begin
                        rx_sh <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end
                    default: begin
                        rx_state    <= S_IDLE;
                        rx_push     <= 1'b1;
                        rx_ferr_set <= ~rx_s2;
                    end
                endcase
            end
        end
    end

endmodule
